// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and conditioned level/strobe outputs.
interface button_conditioner_if;
    logic [4:0] btnIn;
    logic [4:0] btnLevel;
    logic [4:0] btnPress;
    modport master (output btnIn, input btnLevel, btnPress);
    modport slave (input btnIn, output btnLevel, btnPress);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and edge-detect five push buttons.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat strobes on L/R (bits 2 and 3).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE = 20000000
) (
    input logic clk,
    input logic rst,
    button_conditioner_if.slave btn
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : gBadParams
        $error("button_conditioner: cycle parameters must be at least 2");
    end

    logic [4:0] sync1, sync2, level, press, accept, repStrobe;
    logic [4:0][CW-1:0] cnt;

    always_comb begin
        accept = '0;
        for (int k = 0; k < 5; k++) accept[k] = sync2[k] != level[k] && cnt[k] == CNT_LAST;
    end

    // repStrobe only fires while held, so masking with accept suppresses it on release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            cnt <= '0;
        end else begin
            sync1 <= btn.btnIn;
            sync2 <= sync1;
            level <= level ^ accept;
            press <= (accept & ~level) | (repStrobe & ~accept);
            for (int k = 0; k < 5; k++) cnt[k] <= (sync2[k] == level[k] || accept[k]) ? '0 : cnt[k] + 1'b1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int TW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

    logic [1:0][TW-1:0] holdTmr;
    logic [1:0] repeating;

    always_comb begin
        repStrobe = '0;
        for (int k = 0; k < 2; k++)
            repStrobe[k+2] = level[k+2] && holdTmr[k] == (repeating[k] ? RATE_LAST : DELAY_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdTmr <= '0;
            repeating <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!level[k+2] || accept[k+2]) begin
                    holdTmr[k] <= '0;
                    repeating[k] <= 1'b0;
                end else if (repStrobe[k+2]) begin
                    holdTmr[k] <= '0;
                    repeating[k] <= 1'b1;
                end else begin
                    holdTmr[k] <= holdTmr[k] + 1'b1;
                end
            end
        end
    end
`else
    assign repStrobe = '0;
`endif

    assign btn.btnLevel = level;
    assign btn.btnPress = press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked against a window-based model.
module tb_button_conditioner;
    localparam int DB = 4, RD = 20, RR = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] level, press, p0, p1;
        logic [DB-1:0][4:0] win;
        logic [31:0] t;
        logic [4:0][31:0] pt;
    } mstate_t;

    logic clk = 1'b0, rst = 1'b0;
    int tests = 0, fails = 0, cyc = 0;
    mstate_t m = '0;

    button_conditioner_if bus();
    button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst(rst), .btn(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // level flips once the last DB synchronized samples all disagree with it;
    // repeats fall on press time + RD + n*RR while still held
    function automatic mstate_t step(mstate_t s, logic [4:0] in);
        mstate_t n = s;
        logic flip;
        int d;
        n.t = s.t + 1;
        n.win = {s.win[DB-2:0], s.p1};
        n.p1 = s.p0;
        n.p0 = in;
        n.press = '0;
        for (int i = 0; i < 5; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++) if (n.win[j][i] == s.level[i]) flip = 1'b0;
            n.level[i] = s.level[i] ^ flip;
            if (flip && !s.level[i]) begin
                n.press[i] = 1'b1;
                n.pt[i] = n.t;
            end else if (AR && (i == 2 || i == 3) && s.level[i] && n.level[i]) begin
                d = int'(n.t - s.pt[i]);
                if (d >= RD && (d - RD) % RR == 0) n.press[i] = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) m <= !rst ? '0 : step(m, bus.btnIn);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) check("model", {bus.btnLevel, bus.btnPress}, {m.level, m.press});

    task automatic waitPress(input int b, output int at);
        at = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.btnPress[b]) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.btnIn = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s, at, n, t0;
        int rep[$];
        bus.btnIn = 5'h1F;
        repeat (4) begin
            @(negedge clk);
            check("reset_level", bus.btnLevel, 0);
            check("reset_press", bus.btnPress, 0);
        end
        rst = 1'b1;
        s = cyc + 1;
        waitPress(0, at);
        check("rst_hold_latency", at - s, 5);
        check("rst_hold_press", bus.btnPress, 5'h1F);
        check("rst_hold_level", bus.btnLevel, 5'h1F);
        @(negedge clk);
        check("strobe_width", bus.btnPress, 0);
        idle(12);

        bus.btnIn = 5'h10;
        s = cyc + 1;
        waitPress(4, at);
        check("c_press_latency", at - s, 5);
        @(negedge clk);
        check("c_press_width", bus.btnPress[4], 0);
        check("c_level", bus.btnLevel[4], 1);
        repeat (5) @(negedge clk);
        bus.btnIn = '0;
        s = cyc + 1;
        n = 0;
        at = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n += int'(bus.btnPress[4]);
            if (at < 0 && !bus.btnLevel[4]) at = cyc;
        end
        check("c_release_latency", at - s, 5);
        check("c_release_strobes", n, 0);

        n = 0;
        for (int k = 0; k < 40;) begin
            int len = $urandom_range(1, 3);
            bus.btnIn[0] = ~bus.btnIn[0];
            repeat (len) begin
                @(negedge clk);
                n += int'(bus.btnPress[0]);
            end
            k += len;
        end
        if (bus.btnIn[0]) begin
            bus.btnIn[0] = 1'b0;
            @(negedge clk);
            n += int'(bus.btnPress[0]);
        end
        check("bounce_strobes", n, 0);
        bus.btnIn[0] = 1'b1;
        s = cyc + 1;
        n = 0;
        at = -1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.btnPress[0]) begin
                n++;
                at = cyc;
            end
        end
        check("settle_strobes", n, 1);
        check("settle_latency", at - s, 5);
        idle(12);

        bus.btnIn = 5'h08;
        s = cyc + 1;
        waitPress(3, at);
        check("r_press_latency", at - s, 5);
        t0 = at;
        while (cyc < t0 + 56) begin
            @(negedge clk);
            if (bus.btnPress[3]) rep.push_back(cyc - t0);
        end
        check("repeat_count", rep.size(), AR ? 5 : 0);
        foreach (rep[k]) check("repeat_offset", rep[k], RD + RR * k);
        bus.btnIn = '0;
        for (int k = 0; k < 20 && bus.btnLevel[3]; k++) @(negedge clk);
        check("r_released", bus.btnLevel[3], 0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            n += int'(bus.btnPress[3]);
        end
        check("r_after_release", n, 0);

        bus.btnIn = 5'h10;
        waitPress(4, at);
        bus.btnIn = 5'h12;
        s = cyc + 1;
        while (cyc < s + 3) @(negedge clk);
        check("pre_reset_level", bus.btnLevel, 5'h10);
        #2 rst = 1'b0;
        #1;
        check("async_reset_level", bus.btnLevel, 0);
        check("async_reset_press", bus.btnPress, 0);
        @(negedge clk);
        rst = 1'b1;
        s = cyc + 1;
        waitPress(1, at);
        check("post_reset_latency", at - s, 5);
        check("post_reset_press", bus.btnPress, 5'h12);
        idle(12);

        bus.btnIn = 5'b01100;
        s = cyc + 1;
        waitPress(2, at);
        check("lr_latency", at - s, 5);
        check("lr_both", bus.btnPress[3:2], 2'b11);
        check("lr_d_press", bus.btnPress[1], 0);
        check("lr_d_level", bus.btnLevel[1], 0);
        idle(12);

        for (int blk = 0; blk < 15; blk++) begin
            int lim = $urandom_range(0, 1) ? 2 : 39;
            repeat (200) begin
                @(negedge clk);
                for (int i = 0; i < 5; i++)
                    if ($urandom_range(0, lim) == 0) bus.btnIn[i] = ~bus.btnIn[i];
            end
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
